// File: rtl/db_array.sv
// Multi-channel switch debouncer: per-channel synchroniser, settle FSM with
// down-counter, registered level/edge outputs and a combined tick flag.
module db_array #(
  parameter int   N           = 4,
  parameter int   CNT_W       = 20,
  parameter int   SYNC_STAGES = 2,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw,
  input  logic [N-1:0] en,
  output logic [N-1:0] db_level,
  output logic [N-1:0] rise_tick,
  output logic [N-1:0] fall_tick,
  output logic         any_tick
);

  localparam logic [1:0] ST_ZERO  = 2'd0;
  localparam logic [1:0] ST_WAIT1 = 2'd1;
  localparam logic [1:0] ST_ONE   = 2'd2;
  localparam logic [1:0] ST_WAIT0 = 2'd3;
  localparam logic [1:0] ST_INIT  = INIT_LEVEL ? ST_ONE : ST_ZERO;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [N-1:0] rise_d;
  logic [N-1:0] fall_d;
  logic         any_q;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [1:0]             state_q, state_d;
      logic [CNT_W-1:0]       cnt_q, cnt_d;
      logic                   level_q, level_d;
      logic                   rise_q, fall_q;
      logic                   rise_c, fall_c;
      logic                   sync_bit;

      assign sync_bit = sync_q[SYNC_STAGES-1];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], sw[gi]};
        end
      end

      // Entering a WAIT state always reloads the full window, so bounces never accumulate.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_c  = 1'b0;
        fall_c  = 1'b0;
        if (!en[gi]) begin
          state_d = level_q ? ST_ONE : ST_ZERO;
          cnt_d   = '0;
        end else begin
          case (state_q)
            ST_ZERO: begin
              if (sync_bit) begin
                state_d = ST_WAIT1;
                cnt_d   = CNT_MAX;
              end else begin
                cnt_d   = '0;
              end
            end
            ST_WAIT1: begin
              if (!sync_bit) begin
                state_d = ST_ZERO;
                cnt_d   = '0;
              end else if (cnt_q != '0) begin
                cnt_d   = cnt_q - CNT_ONE;
              end else begin
                state_d = ST_ONE;
                level_d = 1'b1;
                rise_c  = 1'b1;
              end
            end
            ST_ONE: begin
              if (!sync_bit) begin
                state_d = ST_WAIT0;
                cnt_d   = CNT_MAX;
              end else begin
                cnt_d   = '0;
              end
            end
            default: begin
              if (sync_bit) begin
                state_d = ST_ONE;
                cnt_d   = '0;
              end else if (cnt_q != '0) begin
                cnt_d   = cnt_q - CNT_ONE;
              end else begin
                state_d = ST_ZERO;
                level_d = 1'b0;
                fall_c  = 1'b1;
              end
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= ST_INIT;
          cnt_q   <= '0;
          level_q <= INIT_LEVEL;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          rise_q  <= rise_c;
          fall_q  <= fall_c;
        end
      end

      assign rise_d[gi]    = rise_c;
      assign fall_d[gi]    = fall_c;
      assign db_level[gi]  = level_q;
      assign rise_tick[gi] = rise_q;
      assign fall_tick[gi] = fall_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |{rise_d, fall_d};
    end
  end

  assign any_tick = any_q;

endmodule

// File: doc/db_array.md
DB_ARRAY -- requirements
Module: db_array

Interface
REQ-001 Parameter N, default 4: number of independent switch channels, 1..32.
REQ-002 Parameter CNT_W, default 20: settle counter width; settle window is 2^CNT_W cycles (~21 ms at 50 MHz).
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth, 2..4.
REQ-004 Parameter INIT_LEVEL, default 1'b0: debounced level of every channel after reset.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-007 sw  input  N  raw asynchronous switch inputs, one bit per channel.
REQ-008 en  input  N  per-channel enable; 0 freezes that channel's debounced level and suppresses its ticks.
REQ-009 db_level  output  N  debounced stable level per channel, registered.
REQ-010 rise_tick  output  N  one-cycle pulse per channel on a debounced 0->1 change, registered.
REQ-011 fall_tick  output  N  one-cycle pulse per channel on a debounced 1->0 change, registered.
REQ-012 any_tick  output  1  OR of all rise_tick and fall_tick bits in the same cycle, registered.

Function
REQ-013 Each sw bit SHALL pass through its own SYNC_STAGES-deep flop chain; the FSM sees only the last stage (sync[i]).
REQ-014 Each channel SHALL run an independent 4-state FSM: ZERO, WAIT1, ONE, WAIT0, plus a CNT_W-bit down-counter.
REQ-015 ZERO: on sync[i]=1, go to WAIT1 and load the counter with all-ones; otherwise stay.
REQ-016 WAIT1: while sync[i]=1 and counter!=0, decrement; sync[i]=0 returns to ZERO with no output change; sync[i]=1 with counter==0 goes to ONE.
REQ-017 ONE and WAIT0 SHALL behave symmetrically: ONE->WAIT0 on sync[i]=0; WAIT0->ZERO on counter==0 with sync[i]=0; WAIT0->ONE on sync[i]=1.
REQ-018 db_level[i] SHALL be 1 in ONE and WAIT0 and 0 in ZERO and WAIT1, so WAIT states hold the previous stable level.
REQ-019 rise_tick[i] SHALL be 1 for exactly one cycle, aligned with the first cycle db_level[i] reads 1 after WAIT1->ONE; fall_tick[i] likewise for WAIT0->ZERO.
REQ-020 Latency from the first clock edge sampling a new, steady sw[i] value to the db_level[i] change SHALL be exactly SYNC_STAGES + 2^CNT_W + 1 cycles.
REQ-021 A pulse or bounce on sw[i] shorter than 2^CNT_W cycles after synchronisation SHALL cause no db_level, rise_tick or fall_tick change.
REQ-022 Each bounce SHALL restart the full settle window: re-entry into a WAIT state always reloads all-ones, with no accumulation across bounces.
REQ-023 en[i]=0 SHALL force the channel FSM to the state matching the current db_level[i] (ZERO or ONE), hold the counter at 0, and force both ticks low; the synchroniser keeps running.
REQ-024 On en[i] 0->1, the channel SHALL resume from its held stable state; if the synchronised input differs, a full settle window applies.
REQ-025 Channels SHALL NOT interact; simultaneous ticks on several channels SHALL all assert, and any_tick SHALL be 1 in that cycle.
REQ-026 Counter arithmetic SHALL be unsigned CNT_W-bit, never wrap below 0, and never be decremented outside WAIT states.

Reset
REQ-027 While reset=0, asynchronously: all synchroniser flops = INIT_LEVEL, db_level = {N{INIT_LEVEL}}, FSM = ONE if INIT_LEVEL else ZERO, counters = 0, rise_tick = fall_tick = any_tick = 0.
REQ-028 Reset asserted mid-settle SHALL abort the window with no tick; after release, a channel whose sw differs from INIT_LEVEL SHALL require a full latency per REQ-020.
REQ-029 No tick SHALL be produced by reset release itself.

Verification (N=4, CNT_W=4, SYNC_STAGES=2, INIT_LEVEL=0)
REQ-030 sw[0] 0->1 held 40 cycles -> db_level[0]=1 exactly 19 cycles after the first sampling edge; rise_tick[0] and any_tick high for 1 cycle; other channels unchanged.
REQ-031 sw[1] bounces 1/0 with 10-cycle phases six times, then holds 1 -> no tick during the bounces; rise_tick[1] 19 cycles after the final 0->1 edge.
REQ-032 db_level[2]=1, then sw[2]=0 for 8 cycles and back to 1 -> no fall_tick[2]; db_level[2] stays 1.
REQ-033 sw[0] and sw[3] rise on the same edge -> rise_tick[0] and rise_tick[3] in the same cycle; any_tick is a single 1-cycle pulse.
REQ-034 en[1]=0 while sw[1] toggles and settles at 1 for 30 cycles -> db_level[1] stays 0 with no ticks; en[1]=1 -> rise_tick[1] after 16+1 cycles.
REQ-035 reset pulsed low for 1 cycle mid-WAIT1 on channel 0 -> immediate db_level=0 and no tick; with sw[0] held 1, rise_tick[0] 19 cycles after release.
